sram_ctrl: RTL

Parametrised SRAM controller between the CPU MEM stage and the external 16-bit asynchronous SRAM.
- Turns one word read or write into a sequence of half-word SRAM accesses, with programmable wait states.
- Supports line-sized read bursts for a data cache.
- Raises `busy` to freeze the pipeline until the access completes.

---
 rtl/sram_pkg.sv | 39 +++
 rtl/sram_beat_cnt.sv | 58 +++++
 rtl/sram_ctrl.sv | 177 +++++++++++++++++
 3 files changed

// File: rtl/sram_pkg.sv
// ---------------------------------------------------------------------------
// sram_pkg
// Shared definitions for the SRAM controller slice:
//   - FSM state encoding (plain 2-bit localparams so older code can use them)
//   - default parameter values for sram_ctrl
//   - clog2 / idx_w helpers for sizing counters and index fields
// ---------------------------------------------------------------------------
package sram_pkg;

    // FSM state encoding
    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] READ  = 2'd1;
    localparam logic [1:0] WRITE = 2'd2;
    localparam logic [1:0] DONE  = 2'd3;

    // Default parameter values
    localparam int DEF_DATA_W    = 32;
    localparam int DEF_DQ_W      = 16;
    localparam int DEF_SRAM_AW   = 18;
    localparam int DEF_BASE_ADDR = 1024;
    localparam int DEF_WAIT      = 1;
    localparam int DEF_BURST     = 1;

    // Ceiling log2; clog2(1) = 0.
    function automatic int clog2(input int value);
        int result;
        result = 0;
        for (int v = value - 1; v > 0; v = v >> 1) begin
            result++;
        end
        return result;
    endfunction

    // Width of an index field able to hold 0..count-1, never narrower than 1.
    function automatic int idx_w(input int count);
        return (count > 1) ? clog2(count) : 1;
    endfunction

endpackage

// File: rtl/sram_beat_cnt.sv
// ---------------------------------------------------------------------------
// sram_beat_cnt
// Nested wait/beat counter. wait_cnt runs 0..WAIT inside one beat; when it
// reaches WAIT the beat index advances.
// Ports:
//   clk, rst    clock, asynchronous active-low reset
//   clear       zero both counters (held while the controller is idle)
//   enable      count while an access is in progress
//   last_beat   index of the final beat of the current access
//   beat        current beat index
//   beat_done   final cycle of the current beat
//   last        final cycle of the final beat
// ---------------------------------------------------------------------------
module sram_beat_cnt
    import sram_pkg::*;
#(
    parameter  int WAIT      = DEF_WAIT,
    parameter  int MAX_BEATS = 2,
    localparam int BW        = idx_w(MAX_BEATS)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          clear,
    input  logic          enable,
    input  logic [BW-1:0] last_beat,
    output logic [BW-1:0] beat,
    output logic          beat_done,
    output logic          last
);

    localparam int            WW       = idx_w(WAIT + 1);
    localparam logic [WW-1:0] WAIT_MAX = WW'(WAIT);

    logic [WW-1:0] wait_cnt;

    assign beat_done = enable && (wait_cnt == WAIT_MAX);
    assign last      = beat_done && (beat == last_beat);

    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples the pre-edge values of the others.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wait_cnt <= '0;
            beat     <= '0;
        end else if (clear) begin
            wait_cnt <= '0;
            beat     <= '0;
        end else if (enable) begin
            if (wait_cnt == WAIT_MAX) begin
                wait_cnt <= '0;
                beat     <= beat + BW'(1);
            end else begin
                wait_cnt <= wait_cnt + WW'(1);
            end
        end
    end

endmodule

// File: rtl/sram_ctrl.sv
// ---------------------------------------------------------------------------
// sram_ctrl
// Bridges the CPU MEM stage to a 16-bit asynchronous SRAM. A word write is
// split into DATA_W/DQ_W half-word beats; a read fetches BURST words as a
// line-aligned burst. Each beat lasts WAIT+1 cycles.
// Ports:
//   clk, rst           clock, asynchronous active-low reset
//   rd_en, wr_en       CPU requests, held while busy (write wins on a tie)
//   addr, wdata        CPU byte address (word aligned) and write data
//   rdata              read line, word 0 in the low bits
//   ready              one-cycle completion pulse
//   busy               pipeline freeze
//   SRAM_DQ            bidirectional SRAM data bus
//   SRAM_ADDR          SRAM half-word address
//   SRAM_*_N           active-low SRAM controls
// ---------------------------------------------------------------------------
module sram_ctrl
    import sram_pkg::*;
#(
    parameter int DATA_W    = DEF_DATA_W,
    parameter int DQ_W      = DEF_DQ_W,
    parameter int SRAM_AW   = DEF_SRAM_AW,
    parameter int BASE_ADDR = DEF_BASE_ADDR,
    parameter int WAIT      = DEF_WAIT,
    parameter int BURST     = DEF_BURST
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    rd_en,
    input  logic                    wr_en,
    input  logic [31:0]             addr,
    input  logic [DATA_W-1:0]       wdata,
    output logic [DATA_W*BURST-1:0] rdata,
    output logic                    ready,
    output logic                    busy,
    inout  wire  [DQ_W-1:0]         SRAM_DQ,
    output logic [SRAM_AW-1:0]      SRAM_ADDR,
    output logic                    SRAM_UB_N,
    output logic                    SRAM_LB_N,
    output logic                    SRAM_WE_N,
    output logic                    SRAM_CE_N,
    output logic                    SRAM_OE_N
);

    localparam int N          = DATA_W / DQ_W;   // half-words per word
    localparam int MAX_BEATS  = N * BURST;       // beats of a read burst
    localparam int BW         = idx_w(MAX_BEATS);
    localparam int HW_SHIFT   = clog2(DQ_W / 8);
    localparam int LINE_SHIFT = clog2(MAX_BEATS);

    localparam logic [BW-1:0]      WR_LAST   = BW'(N - 1);
    localparam logic [BW-1:0]      RD_LAST   = BW'(MAX_BEATS - 1);
    localparam logic [SRAM_AW-1:0] LINE_MASK = ~SRAM_AW'((1 << LINE_SHIFT) - 1);
    localparam logic [31:0]        BASE      = 32'(BASE_ADDR);

    logic [1:0]         state;
    logic [DATA_W-1:0]  wdata_q;
    logic [SRAM_AW-1:0] hw_base;
    logic [BW-1:0]      beat;
    logic [BW-1:0]      last_beat;
    logic               beat_done;
    logic               last;
    logic               active;
    logic [DQ_W-1:0]    dq_out;

    // Half-word address of the request; bits above SRAM_AW fall away, so
    // the SRAM space wraps.
    assign hw_base = SRAM_AW'((addr - BASE) >> HW_SHIFT);

    assign active    = (state == READ) || (state == WRITE);
    assign last_beat = (state == WRITE) ? WR_LAST : RD_LAST;

    sram_beat_cnt #(
        .WAIT      (WAIT),
        .MAX_BEATS (MAX_BEATS)
    ) u_beat_cnt (
        .clk       (clk),
        .rst       (rst),
        .clear     (state == IDLE),
        .enable    (active),
        .last_beat (last_beat),
        .beat      (beat),
        .beat_done (beat_done),
        .last      (last)
    );

    // FSM plus address register. SRAM_ADDR is registered so it is glitch
    // free and simply holds its last value while idle.
    // NOTE: wdata_q is reset along with the control state; it never needs a
    // defined value before a write loads it, but resetting it keeps the
    // register bank uniform and costs nothing functionally.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state     <= IDLE;
            SRAM_ADDR <= '0;
            wdata_q   <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (wr_en) begin
                        state     <= WRITE;
                        SRAM_ADDR <= hw_base;
                        wdata_q   <= wdata;
                    end else if (rd_en) begin
                        state     <= READ;
                        SRAM_ADDR <= hw_base & LINE_MASK;
                    end
                end
                READ, WRITE: begin
                    if (last) begin
                        state <= DONE;
                    end else if (beat_done) begin
                        SRAM_ADDR <= SRAM_ADDR + SRAM_AW'(1);
                    end
                end
                DONE:    state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

    // Read capture: the bus is sampled on the final cycle of each beat,
    // giving the SRAM the full WAIT+1 cycles to settle.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rdata <= '0;
        end else if ((state == READ) && beat_done) begin
            for (int i = 0; i < MAX_BEATS; i++) begin
                if (beat == BW'(i)) begin
                    rdata[i*DQ_W +: DQ_W] <= SRAM_DQ;
                end
            end
        end
    end

    // NOTE: every always_comb output gets a default first so no path leaves
    // it unassigned and no latch is inferred.
    always_comb begin
        dq_out = '0;
        for (int i = 0; i < N; i++) begin
            if (beat == BW'(i)) begin
                dq_out = wdata_q[i*DQ_W +: DQ_W];
            end
        end
    end

    assign SRAM_DQ = (state == WRITE) ? dq_out : {DQ_W{1'bz}};

    always_comb begin
        SRAM_CE_N = 1'b1;
        SRAM_OE_N = 1'b1;
        SRAM_WE_N = 1'b1;
        SRAM_UB_N = 1'b1;
        SRAM_LB_N = 1'b1;
        case (state)
            READ: begin
                SRAM_CE_N = 1'b0;
                SRAM_OE_N = 1'b0;
                SRAM_UB_N = 1'b0;
                SRAM_LB_N = 1'b0;
            end
            WRITE: begin
                SRAM_CE_N = 1'b0;
                SRAM_WE_N = 1'b0;
                SRAM_UB_N = 1'b0;
                SRAM_LB_N = 1'b0;
            end
            default: ;
        endcase
    end

    // busy is gated by rst so a request still held during reset does not
    // freeze the pipeline while the controller is being reset.
    assign busy  = rst && (((state == IDLE) && (rd_en || wr_en)) || active);
    assign ready = (state == DONE);

endmodule
